// File: rtl/bram_clear_dp.sv
// Dual-channel block RAM with per-byte write masks and a hardware clear sequencer.
// The sequencer clears the whole array after reset and clears sub-ranges on command.
module bram_clear_dp #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SIZE           = 32'h400,
  parameter int unsigned ADDR_LSH       = 2,
  parameter logic [31:0] CLEAR_VALUE    = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  output logic               o_initialized,
  input  logic               i_clear,
  input  logic [31:0]        i_clear_base,
  input  logic [31:0]        i_clear_count,
  input  logic               i_a_request,
  input  logic               i_a_rw,
  input  logic [31:0]        i_a_address,
  input  logic [WIDTH-1:0]   i_a_wdata,
  input  logic [WIDTH/8-1:0] i_a_wmask,
  output logic [WIDTH-1:0]   o_a_rdata,
  output logic               o_a_ready,
  input  logic               i_b_request,
  input  logic               i_b_rw,
  input  logic [31:0]        i_b_address,
  input  logic [WIDTH-1:0]   i_b_wdata,
  input  logic [WIDTH/8-1:0] i_b_wmask,
  output logic [WIDTH-1:0]   o_b_rdata,
  output logic               o_b_ready
);
  localparam int unsigned NB      = WIDTH / 8;
  localparam int unsigned AW      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [WIDTH-1:0] CLR = WIDTH'(CLEAR_VALUE);
  localparam logic [32:0] SIZE_W  = 33'(SIZE);
  localparam logic [32:0] END_RST = CLEAR_ON_RESET ? SIZE_W : 33'd0;

  logic [WIDTH-1:0] mem [SIZE];

  logic [32:0] ptr_q, ptr_d, end_q, end_d, clr_sum;

  // Clear range bookkeeping; sum at 33 bits so base+count never wraps
  always_comb begin
    ptr_d   = ptr_q;
    end_d   = end_q;
    clr_sum = {1'b0, i_clear_base} + {1'b0, i_clear_count};
    if (!o_initialized) begin
      ptr_d = ptr_q + 33'd1;
    end else if (i_clear) begin
      ptr_d = {1'b0, i_clear_base};
      end_d = (clr_sum < SIZE_W) ? clr_sum : SIZE_W;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q         <= 33'd0;
      end_q         <= END_RST;
      o_initialized <= (END_RST == 33'd0);
    end else begin
      ptr_q         <= ptr_d;
      end_q         <= end_d;
      o_initialized <= (ptr_d >= end_d);
    end
  end

  logic [31:0]   a_idx, b_idx;
  logic [AW-1:0] a_wa, b_wa;
  logic          a_inr, b_inr, a_acc, b_acc;

  assign a_idx = i_a_address >> ADDR_LSH;
  assign b_idx = i_b_address >> ADDR_LSH;
  assign a_wa  = a_idx[AW-1:0];
  assign b_wa  = b_idx[AW-1:0];
  assign a_inr = ({1'b0, a_idx} < SIZE_W);
  assign b_inr = ({1'b0, b_idx} < SIZE_W);
  assign a_acc = i_a_request && o_initialized && !o_a_ready;
  assign b_acc = i_b_request && o_initialized && !o_b_ready;

  // Array writes; A is applied last so its enabled bytes win a same-word collision
  always_ff @(posedge i_clock) begin
    if (!o_initialized) begin
      mem[ptr_q[AW-1:0]] <= CLR;
    end
    for (int n = 0; n < NB; n++) begin
      if (b_acc && i_b_rw && b_inr && i_b_wmask[n]) begin
        mem[b_wa][8*n +: 8] <= i_b_wdata[8*n +: 8];
      end
      if (a_acc && i_a_rw && a_inr && i_a_wmask[n]) begin
        mem[a_wa][8*n +: 8] <= i_a_wdata[8*n +: 8];
      end
    end
  end

  // Completion pulses and read data; reads see the pre-write contents
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_a_ready <= 1'b0;
      o_b_ready <= 1'b0;
      o_a_rdata <= '0;
      o_b_rdata <= '0;
    end else begin
      o_a_ready <= a_acc;
      o_b_ready <= b_acc;
      if (a_acc && !i_a_rw) begin
        o_a_rdata <= a_inr ? mem[a_wa] : CLR;
      end
      if (b_acc && !i_b_rw) begin
        o_b_rdata <= b_inr ? mem[b_wa] : CLR;
      end
    end
  end

endmodule

// File: tb/tb_bram_clear_dp.sv
// Bench for bram_clear_dp: directed scenarios plus random traffic, checked every cycle
// against a queue/array model of the memory and clear sequencer.
module tb_bram_clear_dp;
  localparam logic [31:0] CLR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        initialized;
  logic        clear;
  logic [31:0] clear_base, clear_count;
  logic        a_request, a_rw, b_request, b_rw;
  logic [31:0] a_address, a_wdata, b_address, b_wdata;
  logic [3:0]  a_wmask, b_wmask;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, b_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_clear_dp #(
    .WIDTH(32), .SIZE(16), .ADDR_LSH(2), .CLEAR_VALUE(CLR), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .o_initialized(initialized),
    .i_clear(clear), .i_clear_base(clear_base), .i_clear_count(clear_count),
    .i_a_request(a_request), .i_a_rw(a_rw), .i_a_address(a_address),
    .i_a_wdata(a_wdata), .i_a_wmask(a_wmask), .o_a_rdata(a_rdata), .o_a_ready(a_ready),
    .i_b_request(b_request), .i_b_rw(b_rw), .i_b_address(b_address),
    .i_b_wdata(b_wdata), .i_b_wmask(b_wmask), .o_b_rdata(b_rdata), .o_b_ready(b_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array plus a queue of words still waiting to be cleared
  logic [31:0] m_mem [16];
  int          clr_q[$];
  logic        e_init, e_ready_a, e_ready_b;
  logic [31:0] e_rdata_a, e_rdata_b;
  logic        m_busy, m_acc_a, m_acc_b;
  logic [31:0] m_ia, m_ib;
  int          m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ready_a = 1'b0; e_ready_b = 1'b0;
      e_rdata_a = '0;   e_rdata_b = '0;
      clr_q.delete();
      for (int i = 0; i < 16; i++) clr_q.push_back(i);
      e_init = 1'b0;
    end else begin
      m_busy  = (clr_q.size() != 0);
      m_acc_a = a_request && !m_busy && !e_ready_a;
      m_acc_b = b_request && !m_busy && !e_ready_b;
      m_ia = a_address >> 2;
      m_ib = b_address >> 2;
      if (m_acc_a && !a_rw) e_rdata_a = (m_ia < 16) ? m_mem[m_ia[3:0]] : CLR;
      if (m_acc_b && !b_rw) e_rdata_b = (m_ib < 16) ? m_mem[m_ib[3:0]] : CLR;
      for (int n = 0; n < 4; n++) begin
        if (m_acc_b && b_rw && m_ib < 16 && b_wmask[n]) m_mem[m_ib[3:0]][8*n +: 8] = b_wdata[8*n +: 8];
        if (m_acc_a && a_rw && m_ia < 16 && a_wmask[n]) m_mem[m_ia[3:0]][8*n +: 8] = a_wdata[8*n +: 8];
      end
      e_ready_a = m_acc_a;
      e_ready_b = m_acc_b;
      if (m_busy) begin
        m_w = clr_q.pop_front();
        m_mem[m_w[3:0]] = CLR;
      end else if (clear) begin
        for (longint i = longint'(clear_base);
             i < longint'(clear_base) + longint'(clear_count) && i < 16; i++)
          clr_q.push_back(int'(i));
      end
      e_init = (clr_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    chk("initialized", 32'(initialized), 32'(e_init));
    chk("a_ready", 32'(a_ready), 32'(e_ready_a));
    chk("b_ready", 32'(b_ready), 32'(e_ready_b));
    chk("a_rdata", a_rdata, e_rdata_a);
    chk("b_rdata", b_rdata, e_rdata_b);
  end

  task automatic idle();
    a_request = 0; a_rw = 0; a_address = 0; a_wdata = 0; a_wmask = 0;
    b_request = 0; b_rw = 0; b_address = 0; b_wdata = 0; b_wmask = 0;
    clear = 0; clear_base = 0; clear_count = 0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!initialized && n < 100);
  endtask

  task automatic txn_a(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, output logic [31:0] rd);
    @(negedge clk);
    a_request = 1; a_rw = rw; a_address = addr; a_wdata = data; a_wmask = mask;
    @(negedge clk);
    a_request = 0;
    chk("a_ready_pulse", 32'(a_ready), 32'd1);
    rd = a_rdata;
  endtask

  task automatic txn_ab(input bit rwa, input logic [31:0] aa, input logic [31:0] da, input logic [3:0] ma,
                        input bit rwb, input logic [31:0] ab, input logic [31:0] db, input logic [3:0] mb,
                        output logic [31:0] rda, output logic [31:0] rdb);
    @(negedge clk);
    a_request = 1; a_rw = rwa; a_address = aa; a_wdata = da; a_wmask = ma;
    b_request = 1; b_rw = rwb; b_address = ab; b_wdata = db; b_wmask = mb;
    @(negedge clk);
    a_request = 0; b_request = 0;
    chk("ab_ready_pulse", {30'd0, a_ready, b_ready}, 32'd3);
    rda = a_rdata; rdb = b_rdata;
  endtask

  task automatic clear_busy(input logic [31:0] base, input logic [31:0] count,
                            input bit reissue, output int busy);
    @(negedge clk);
    clear = 1; clear_base = base; clear_count = count;
    @(negedge clk);
    clear = reissue; clear_base = 0; clear_count = 16;
    busy = 0;
    while (!initialized && busy < 100) begin
      busy++;
      @(negedge clk);
      clear = 0;
    end
    clear = 0;
  endtask

  logic [31:0] rd, rd2;
  int          n;
  logic        init_h [8];
  logic        rdy_h [8];
  logic [31:0] rdat_h [8];

  initial begin
    idle();
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_init", 32'(initialized), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    rst_n = 1;

    // Power-up clear
    count_busy(n);
    chk("powerup_busy_cycles", n, 32'd16);
    chk("model_mem0", m_mem[0], CLR);
    txn_a(0, 32'h00, 0, 0, rd); chk("read_0x00", rd, CLR);
    txn_a(0, 32'h3C, 0, 0, rd); chk("read_0x3C", rd, CLR);

    // Byte-masked write
    txn_a(1, 32'h10, 32'h11223344, 4'b0101, rd);
    txn_a(0, 32'h10, 0, 0, rd); chk("masked_write", rd, 32'hDE22BE44);
    chk("model_mem4", m_mem[4], 32'hDE22BE44);

    // Same-word collisions
    txn_ab(1, 32'h20, 32'hAAAAAAAA, 4'hF, 1, 32'h20, 32'h55555555, 4'h3, rd, rd2);
    txn_a(0, 32'h20, 0, 0, rd); chk("ww_collision", rd, 32'hAAAAAAAA);
    chk("model_mem8", m_mem[8], 32'hAAAAAAAA);
    txn_ab(1, 32'h24, 32'h12345678, 4'hF, 0, 32'h24, 0, 0, rd, rd2);
    chk("wr_collision_old", rd2, CLR);
    txn_a(0, 32'h24, 0, 0, rd); chk("wr_collision_new", rd, 32'h12345678);

    // Range clear with a held request
    for (int i = 3; i < 8; i++) txn_a(1, 32'(i * 4), {4{8'(i * 17)}}, 4'hF, rd);
    @(negedge clk);
    a_request = 1; a_rw = 0; a_address = 32'h10;
    clear = 1; clear_base = 4; clear_count = 3;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      init_h[k] = initialized; rdy_h[k] = a_ready; rdat_h[k] = a_rdata;
      clear = 0;
    end
    @(negedge clk); a_request = 0;
    chk("rc_accept_at_cmd", 32'(rdy_h[0]), 32'd1);
    chk("rc_old_data", rdat_h[0], 32'h44444444);
    chk("rc_busy_last", 32'(init_h[2]), 32'd0);
    chk("rc_init_rise", 32'(init_h[3]), 32'd1);
    chk("rc_no_ready_at_rise", 32'(rdy_h[3]), 32'd0);
    chk("rc_ready_after_rise", 32'(rdy_h[4]), 32'd1);
    chk("rc_rdata_after_rise", rdat_h[4], CLR);
    txn_a(0, 32'h0C, 0, 0, rd); chk("rc_word3", rd, 32'h33333333);
    txn_a(0, 32'h14, 0, 0, rd); chk("rc_word5", rd, CLR);
    txn_a(0, 32'h18, 0, 0, rd); chk("rc_word6", rd, CLR);
    txn_a(0, 32'h1C, 0, 0, rd); chk("rc_word7", rd, 32'h77777777);

    // Clipped, ignored and no-op clears
    clear_busy(14, 100, 1'b0, n); chk("clip_busy", n, 32'd2);
    clear_busy(14, 100, 1'b1, n); chk("reissue_ignored", n, 32'd2);
    clear_busy(3, 0, 1'b0, n);    chk("count0_noop", n, 32'd0);
    clear_busy(20, 5, 1'b0, n);   chk("base_oob_noop", n, 32'd0);
    clear_busy(32'hFFFFFFF0, 32'h20, 1'b0, n); chk("wrap_base_noop", n, 32'd0);
    clear_busy(2, 32'hFFFFFFFF, 1'b0, n);      chk("wide_sum_busy", n, 32'd14);

    // Reset during a clear and a completing read
    @(negedge clk);
    a_request = 1; a_rw = 0; a_address = 32'h10;
    clear = 1; clear_base = 0; clear_count = 16;
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("midrst_ready", 32'(a_ready), 32'd0);
    chk("midrst_rdata", a_rdata, 32'd0);
    chk("midrst_init", 32'(initialized), 32'd0);
    @(negedge clk); idle();
    @(negedge clk); rst_n = 1;
    count_busy(n);
    chk("restart_busy_cycles", n, 32'd16);
    txn_a(1, 32'h40, 32'h12345678, 4'hF, rd);
    txn_a(0, 32'h40, 0, 0, rd); chk("oob_read", rd, CLR);
    txn_a(0, 32'h00, 0, 0, rd); chk("oob_no_alias", rd, CLR);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      a_request = ($urandom_range(0, 2) != 0); a_rw = 1'($urandom_range(0, 1));
      a_address = $urandom_range(0, 79); a_wdata = $urandom; a_wmask = 4'($urandom);
      b_request = ($urandom_range(0, 2) != 0); b_rw = 1'($urandom_range(0, 1));
      b_address = ($urandom_range(0, 3) == 0) ? a_address : 32'($urandom_range(0, 79));
      b_wdata = $urandom; b_wmask = 4'($urandom);
      clear = ($urandom_range(0, 24) == 0);
      clear_base = $urandom_range(0, 20); clear_count = $urandom_range(0, 20);
    end
    @(negedge clk); idle();
    n = 0;
    while (!initialized && n < 100) begin @(negedge clk); n++; end
    chk("final_idle", 32'(initialized), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
